// File: rtl/div_pkg.sv
// Shared definitions for the divider dispatch path: default widths and FSM encoding.
package div_pkg;

  localparam int unsigned DIV_N    = 16;
  localparam int unsigned DIV_TAGW = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HOLD   = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_opfifo.sv
// Operand FIFO for div_dispatch: power-of-two depth, registered ready, head read combinationally.
module div_opfifo #(
  parameter int unsigned W     = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head_c,
  output logic         empty_c,
  output logic         ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          do_push;
  logic          do_pop;

  assign empty_c = (cnt_q == '0);
  assign do_push = push && ready;
  assign do_pop  = pop && !empty_c;
  assign head_c  = mem[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ready <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
      ready <= (cnt_d != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= wdata;
  end

endmodule

// File: rtl/div_dispatch.sv
// Queues signed divide requests and launches them one at a time into an external divider,
// with a completion watchdog and a held result until the consumer accepts it.
module div_dispatch
  import div_pkg::*;
#(
  parameter int unsigned N     = DIV_N,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = DIV_TAGW,
  parameter int unsigned TMO   = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_dividend,
  input  logic [N-1:0]    in_divisor,
  input  logic [TAGW-1:0] in_tag,
  output logic            div_start,
  output logic [N-1:0]    div_dividend,
  output logic [N-1:0]    div_divisor,
  input  logic            div_busy,
  input  logic            div_done,
  input  logic [N-1:0]    div_quotient,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_quotient,
  output logic [TAGW-1:0] out_tag,
  output logic            out_dz,
  output logic            out_err
);

  localparam int unsigned FW  = 2 * N + TAGW;
  localparam int unsigned WDW = $clog2(TMO + 1);

  div_state_e     state_q, state_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [FW-1:0]  head_c;
  logic           empty_c;
  logic           fifo_push;
  logic           pop_c;
  logic           cap_c;
  logic           cap_err_c;
  logic           start_d;
  logic           valid_d;
  logic [N-1:0]   opa_d;
  logic [N-1:0]   opb_d;
  logic [N-1:0]   h_dd;
  logic [N-1:0]   h_dv;
  logic [TAGW-1:0] h_tag;

  assign fifo_push = in_valid && in_ready;
  assign h_dd  = head_c[FW-1 -: N];
  assign h_dv  = head_c[N+TAGW-1 -: N];
  assign h_tag = head_c[TAGW-1:0];

  div_opfifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .pop     (pop_c),
    .wdata   ({in_dividend, in_divisor, in_tag}),
    .head_c  (head_c),
    .empty_c (empty_c),
    .ready   (in_ready)
  );

  // State register and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Next state; done wins over a timeout landing in the same cycle.
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    pop_c     = 1'b0;
    cap_c     = 1'b0;
    cap_err_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_c && !div_busy) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_done) begin
          cap_c   = 1'b1;
          pop_c   = 1'b1;
          state_d = ST_HOLD;
        end else if (wd_q == WDW'(TMO - 1)) begin
          cap_c     = 1'b1;
          cap_err_c = 1'b1;
          pop_c     = 1'b1;
          state_d   = ST_HOLD;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state.
  always_comb begin
    start_d = (state_d == ST_LAUNCH);
    valid_d = (state_d == ST_HOLD);
    opa_d   = '0;
    opb_d   = '0;
    if (state_d == ST_LAUNCH || state_d == ST_WAIT) begin
      opa_d = h_dd;
      opb_d = h_dv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_start    <= 1'b0;
      out_valid    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      div_start    <= start_d;
      out_valid    <= valid_d;
      div_dividend <= opa_d;
      div_divisor  <= opb_d;
    end
  end

  // Result registers, loaded once per request at the end of WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_quotient <= '0;
      out_tag      <= '0;
      out_dz       <= 1'b0;
      out_err      <= 1'b0;
    end else if (cap_c) begin
      out_quotient <= cap_err_c ? '0 : div_quotient;
      out_tag      <= h_tag;
      out_dz       <= (h_dv == '0);
      out_err      <= cap_err_c;
    end
  end

endmodule

// File: tb/tb_div_dispatch.sv
// Scoreboard bench for div_dispatch with a behavioural divider of random latency.
module tb_div_dispatch;

  localparam int unsigned N     = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAGW  = 4;
  localparam int unsigned TMO   = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_dividend;
  logic [N-1:0]    in_divisor;
  logic [TAGW-1:0] in_tag;
  logic            div_start;
  logic [N-1:0]    div_dividend;
  logic [N-1:0]    div_divisor;
  logic            div_busy;
  logic            div_done = 1'b0;
  logic [N-1:0]    div_quotient;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_quotient;
  logic [TAGW-1:0] out_tag;
  logic            out_dz;
  logic            out_err;

  div_dispatch #(.N(N), .DEPTH(DEPTH), .TAGW(TAGW), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_done(div_done), .div_quotient(div_quotient),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_tag(out_tag), .out_dz(out_dz), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    dd;
    logic [N-1:0]    dv;
    logic [N-1:0]    q;
    logic [TAGW-1:0] tag;
    logic            dz;
    logic            err;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   starts = 0;
  int   results = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   occ = 0;
  int   since_rst = 0;
  bit   push_pend = 0;
  bit   prev_ov = 0;
  bit   stall = 0;
  int   lat_cfg = 0;
  int   rdy_mode = 1;
  int   dcnt = 0;
  logic [N-1:0] dq = '0;

  // Truncating signed division; a zero divisor yields zero.
  function automatic logic [N-1:0] ref_div(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
    int q;
    if (b == '0) return '0;
    q = int'(a) / int'(b);
    return N'(q);
  endfunction

  function automatic exp_t make_exp(input logic [N-1:0] dd, input logic [N-1:0] dv, input logic [TAGW-1:0] tg);
    exp_t e;
    e.dd  = dd;
    e.dv  = dv;
    e.tag = tg;
    e.dz  = (dv == '0);
    e.err = stall;
    e.q   = stall ? '0 : ref_div(dd, dv);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: actual=event required=none", nm);
  endtask

  // Divider stand-in: busy for a few cycles after start, then a one-cycle done unless stalled.
  assign div_busy     = (dcnt != 0);
  assign div_quotient = dq;
  always @(posedge clk) begin
    div_done <= 1'b0;
    if (div_start) begin
      dcnt <= (lat_cfg == 0) ? int'($urandom_range(1, 8)) : lat_cfg;
      dq   <= ref_div(div_dividend, div_divisor);
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1 && !stall) div_done <= 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: occupancy / in_ready model, launch operands, and result scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      expq.delete();
      occ = 0;
      push_pend = 0;
      prev_ov = 0;
      since_rst = 0;
    end else begin
      since_rst++;
      if (push_pend) occ++;
      if (out_valid && !prev_ov) occ--;
      if (since_rst > 2) chk("in_ready", 32'(in_ready), 32'(occ < int'(DEPTH)));
      push_pend = in_valid && in_ready;
      if (push_pend) expq.push_back(make_exp(in_dividend, in_divisor, in_tag));
      if (div_start) begin
        starts++;
        start_cyc = cyc;
        if (expq.size() == 0 || out_valid) fail("spurious_start");
        else begin
          chk("launch_dividend", 32'(div_dividend), 32'(expq[0].dd));
          chk("launch_divisor", 32'(div_divisor), 32'(expq[0].dv));
        end
      end
      if (out_valid) begin
        if (expq.size() == 0) fail("unexpected_valid");
        else begin
          if (!prev_ov && expq[0].err) chk("timeout_latency", 32'(cyc - start_cyc), 32'(TMO + 1));
          chk("quotient", 32'(out_quotient), 32'(expq[0].q));
          chk("tag", 32'(out_tag), 32'(expq[0].tag));
          chk("dz", 32'(out_dz), 32'(expq[0].dz));
          chk("err", 32'(out_err), 32'(expq[0].err));
          chk("ops_idle", 32'({div_dividend, div_divisor}), 32'(0));
          if (out_ready) begin
            void'(expq.pop_front());
            results++;
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic push(input int dd, input int dv, input int tg);
    in_valid    = 1'b1;
    in_dividend = N'(dd);
    in_divisor  = N'(dv);
    in_tag      = TAGW'(tg);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    fail("push_timeout");
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int i;
    in_valid = 1'b0;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (expq.size() == 0 && !out_valid) break;
    end
    if (i == 3000) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'(0));
    chk({nm, "_div_start"}, 32'(div_start), 32'(0));
    chk({nm, "_div_ops"}, 32'({div_dividend, div_divisor}), 32'(0));
    chk({nm, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({nm, "_payload"}, 32'({out_quotient, out_tag, out_dz, out_err}), 32'(0));
  endtask

  initial begin
    int s0;
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_dividend = '0;
    in_divisor = '0;
    in_tag = '0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 chk_reset_outputs("por");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(2);
    chk("ready_after_release", 32'(in_ready), 32'(1));

    // Single request
    lat_cfg = 3;
    s0 = starts;
    push(42, 8, 3);
    wait_idle();
    chk("single_start_count", 32'(starts - s0), 32'(1));

    // Back-to-back ordered requests
    lat_cfg = 0;
    push(-100, 3, 1);
    push(100, -3, 2);
    push(7, 3, 4);
    push(0, 5, 5);
    wait_idle();

    // Divide by zero
    push(10, 0, 6);
    wait_idle();

    // Watchdog timeout, then a normal request still launches
    stall = 1;
    push(5, 1, 7);
    wait_idle();
    stall = 0;
    push(9, 2, 8);
    wait_idle();

    // Consumer back-pressure: FIFO fills, result held stable
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) push(1000 + i * 37, i + 2, i);
    idle_cycles(20);
    rdy_mode = 1;
    wait_idle();

    // Random traffic
    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      int dd, dv;
      dd = int'($urandom_range(0, 65535)) - 32768;
      case ($urandom_range(0, 9))
        0:       dv = 0;
        1, 2, 3: dv = int'($urandom_range(0, 16)) - 8;
        default: dv = int'($urandom_range(0, 65535)) - 32768;
      endcase
      push(dd, dv, int'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end
    rdy_mode = 1;
    wait_idle();

    // Reset during WAIT with requests queued; the late done must be ignored
    lat_cfg = 20;
    for (int i = 0; i < 4; i++) push(50 + i, 3, 10 + i);
    idle_cycles(5);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(2);
    chk("ready_after_mid_reset", 32'(in_ready), 32'(1));
    lat_cfg = 0;
    idle_cycles(30);
    chk("no_valid_after_reset", 32'(out_valid), 32'(0));
    push(-77, 7, 9);
    wait_idle();

    // One launched request was discarded by the mid-run reset
    chk("start_total", 32'(starts), 32'(results + 1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_dispatch.md
DIV_DISPATCH -- requirements
Module: div_dispatch

Interface
REQ-001 Parameter N, default 16, operand and quotient width in bits.
REQ-002 Parameter DEPTH, default 4, operand FIFO entries (power of two, >=2).
REQ-003 Parameter TAGW, default 4, request tag width.
REQ-004 Parameter TMO, default 64, watchdog limit in cycles for divider completion.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1: the single clock, rising-edge active.
REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
REQ-008 Ports in_valid, input, 1, and in_ready, output, 1: request handshake.
REQ-009 Ports in_dividend, input, N, and in_divisor, input, N: signed operands.
REQ-010 Port in_tag, input, TAGW: request tag, returned with the result.
REQ-011 Port div_start, output, 1: one-cycle launch pulse to the divider.
REQ-012 Ports div_dividend and div_divisor, output, N each: operands presented to the divider.
REQ-013 Ports div_busy and div_done, input, 1 each, and div_quotient, input, N signed: divider status and result.
REQ-014 Ports out_valid, output, 1, and out_ready, input, 1: result handshake.
REQ-015 Ports out_quotient, output, N, and out_tag, output, TAGW: result payload.
REQ-016 Ports out_dz and out_err, output, 1 each: divide-by-zero flag and watchdog timeout flag.

Function
REQ-017 The operand FIFO SHALL store {dividend, divisor, tag}; a push occurs when in_valid && in_ready; in_ready = !full, registered count only, with no same-cycle bypass when full.
REQ-018 A push and a pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-019 The FSM SHALL have the states IDLE, LAUNCH, WAIT, and HOLD.
REQ-020 IDLE: if the FIFO is non-empty and div_busy=0, go to LAUNCH the next cycle; otherwise stay.
REQ-021 LAUNCH: div_start=1 for exactly this cycle; the watchdog counter is cleared; go to WAIT.
REQ-022 div_dividend and div_divisor SHALL equal the FIFO head from LAUNCH through the end of WAIT, and SHALL be 0 in the other states.
REQ-023 WAIT: on the first cycle with div_done=1, capture div_quotient, the head tag, dz=(head divisor==0) and err=0 into the result registers; pop the FIFO; go to HOLD.
REQ-024 WAIT: if TMO cycles elapse without div_done, capture quotient=0, err=1 and dz as above; pop the FIFO; go to HOLD.
REQ-025 HOLD: out_valid=1 and the payload is stable; on out_ready=1, go to IDLE the next cycle.
REQ-026 div_done SHALL be ignored outside WAIT.
REQ-027 Latency from launch SHALL be the divider latency plus 1 cycle (WAIT to HOLD capture); back-to-back throughput is one result per divider latency plus 3 cycles.
REQ-028 Results SHALL be delivered in FIFO (request) order; a dz result SHALL still launch the divider and report the divider's quotient.

Reset
REQ-029 When rst_n=0 (asynchronous), the following SHALL be cleared: FSM=IDLE, FIFO empty (pointers and count 0), watchdog 0, result registers 0.
REQ-030 Output reset values SHALL be: in_ready=0 while rst_n=0 and 1 after release; div_start=0; div_dividend=0; div_divisor=0; out_valid=0; out_quotient=0; out_tag=0; out_dz=0; out_err=0.
REQ-031 Reset asserted mid-operation SHALL discard all queued and in-flight requests; a late div_done after release is ignored (IDLE).

Structure
REQ-032 The FSM state encoding and the default N and TAGW values SHALL reside in the shared package div_pkg, for reuse by the divider and its benches.
REQ-033 The operand FIFO SHALL be a sub-module, div_opfifo, parameterised by width and DEPTH; the FSM, watchdog and result registers stay in div_dispatch.

Verification
REQ-034 Push (42,8,tag=3) with a div_binsearch instance attached: out_valid rises with quotient=5, tag=3, dz=0, err=0; exactly one div_start pulse is observed.
REQ-035 Push four requests back-to-back, (-100,3), (100,-3), (7,3), (0,5), with out_ready=1: results arrive in order -33, -33, 2, 0; in_ready drops only when the FIFO holds DEPTH entries.
REQ-036 Push (10,0): result has quotient=0 and dz=1.
REQ-037 Tie div_done=0 with a stub divider and push (5,1): after 64 cycles in WAIT, out_err=1 and quotient=0; the next request still launches.
REQ-038 Hold out_ready=0 for 20 cycles: out_valid and the payload stay stable, and no second div_start occurs; on release, the next request launches.
REQ-039 Assert rst_n=0 during WAIT with 3 entries queued: all outputs are at their reset values immediately; after release, in_ready=1 and the FIFO is empty.
